// File: rtl/etapa_busqueda.sv
// ============================================================================
// etapa_busqueda: instruction fetch stage with one outstanding memory request,
// an output register and a 1-entry skid buffer.  Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module etapa_busqueda #(
    parameter int ANCHO_INSTR = 32,
    parameter int ANCHO_PC    = 16,
    parameter int PASO_PC     = 1,
    parameter int PC_INICIO   = 0
) (
    input  logic                   clk,
    input  logic                   reset,
    output logic                   mem_req,
    output logic [ANCHO_PC-1:0]    mem_dir,
    input  logic                   mem_listo,
    input  logic                   mem_ack,
    input  logic [ANCHO_INSTR-1:0] mem_dato,
    input  logic                   stall,
    input  logic                   salto_en,
    input  logic [ANCHO_PC-1:0]    salto_dir,
    output logic [ANCHO_INSTR-1:0] instr,
    output logic [4:0]             opcode,
    output logic                   instr_valida,
    output logic [ANCHO_PC-1:0]    pc_instr
);

    localparam logic [ANCHO_PC-1:0] PC_RESET = ANCHO_PC'(PC_INICIO);
    localparam logic [ANCHO_PC-1:0] PC_PASO  = ANCHO_PC'(PASO_PC);

    logic [ANCHO_PC-1:0]    pc_busq;
    logic                   pendiente;
    logic                   descartar;
    logic [ANCHO_PC-1:0]    tag_pend;
    logic                   b_valida;
    logic [ANCHO_INSTR-1:0] b_instr;
    logic [ANCHO_PC-1:0]    b_pc;

    logic acepta;
    logic consume;
    logic redirige;
    logic ack_ok;

    assign mem_req  = ~pendiente & ~b_valida & ~reset;
    assign mem_dir  = pc_busq;
    assign acepta   = mem_req & mem_listo;
    assign consume  = instr_valida & ~stall;
    assign redirige = consume & salto_en;
    assign ack_ok   = mem_ack & pendiente & ~descartar;
    assign opcode   = instr[ANCHO_INSTR-1 -: 5];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_busq      <= PC_RESET;
            pendiente    <= 1'b0;
            descartar    <= 1'b0;
            tag_pend     <= '0;
            b_valida     <= 1'b0;
            b_instr      <= '0;
            b_pc         <= '0;
            instr        <= '0;
            instr_valida <= 1'b0;
            pc_instr     <= '0;
        end else begin
            if (acepta) begin
                pendiente <= 1'b1;
                tag_pend  <= pc_busq;
                pc_busq   <= pc_busq + PC_PASO;
            end else if (mem_ack) begin
                pendiente <= 1'b0;
            end

            if (redirige) begin
                // A request accepted now or still in flight belongs to the old path.
                pc_busq      <= salto_dir;
                instr_valida <= 1'b0;
                b_valida     <= 1'b0;
                descartar    <= acepta | (pendiente & ~mem_ack);
            end else begin
                if (mem_ack & pendiente & descartar)
                    descartar <= 1'b0;

                if (consume) begin
                    if (b_valida) begin
                        instr    <= b_instr;
                        pc_instr <= b_pc;
                        b_valida <= ack_ok;
                        if (ack_ok) begin
                            b_instr <= mem_dato;
                            b_pc    <= tag_pend;
                        end
                    end else if (ack_ok) begin
                        instr    <= mem_dato;
                        pc_instr <= tag_pend;
                    end else begin
                        instr_valida <= 1'b0;
                    end
                end else if (ack_ok) begin
                    if (instr_valida) begin
                        b_instr  <= mem_dato;
                        b_pc     <= tag_pend;
                        b_valida <= 1'b1;
                    end else begin
                        instr        <= mem_dato;
                        pc_instr     <= tag_pend;
                        instr_valida <= 1'b1;
                    end
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_etapa_busqueda.sv
// ============================================================================
// tb_etapa_busqueda: directed self-checking bench for etapa_busqueda. Rev 1.0
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_etapa_busqueda;

    logic        clk = 1'b0;
    logic        reset;
    logic        mem_req;
    logic [15:0] mem_dir;
    logic        mem_listo;
    logic        mem_ack;
    logic [31:0] mem_dato;
    logic        stall;
    logic        salto_en;
    logic [15:0] salto_dir;
    logic [31:0] instr;
    logic [4:0]  opcode;
    logic        instr_valida;
    logic [15:0] pc_instr;

    int n_checks = 0;
    int n_pass   = 0;

    etapa_busqueda #(
        .ANCHO_INSTR(32),
        .ANCHO_PC   (16),
        .PASO_PC    (1),
        .PC_INICIO  (0)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .mem_req     (mem_req),
        .mem_dir     (mem_dir),
        .mem_listo   (mem_listo),
        .mem_ack     (mem_ack),
        .mem_dato    (mem_dato),
        .stall       (stall),
        .salto_en    (salto_en),
        .salto_dir   (salto_dir),
        .instr       (instr),
        .opcode      (opcode),
        .instr_valida(instr_valida),
        .pc_instr    (pc_instr)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h, expected %h", tag, got, exp);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        reset = 1'b1; mem_listo = 1'b0; mem_ack = 1'b0; mem_dato = '0;
        stall = 1'b0; salto_en = 1'b0; salto_dir = '0;
        cycle(); cycle();
        check("rst_req",   32'(mem_req), 32'd0);
        check("rst_dir",   32'(mem_dir), 32'd0);
        check("rst_valid", 32'(instr_valida), 32'd0);
        check("rst_instr", instr, 32'd0);
        check("rst_op",    32'(opcode), 32'd0);
        check("rst_pc",    32'(pc_instr), 32'd0);
        reset = 1'b0;
        #1;
        check("rel_req", 32'(mem_req), 32'd1);
        check("rel_dir", 32'(mem_dir), 32'd0);

        // first fetch: accept addr 0, ack one cycle later
        mem_listo = 1'b1;
        cycle();
        check("t1_req_busy", 32'(mem_req), 32'd0);
        mem_ack = 1'b1; mem_dato = 32'h0800_0000;
        cycle();
        mem_ack = 1'b0; mem_listo = 1'b0;
        check("t1_valid", 32'(instr_valida), 32'd1);
        check("t1_instr", instr, 32'h0800_0000);
        check("t1_op",    32'(opcode), 32'd1);
        check("t1_pc",    32'(pc_instr), 32'd0);
        check("t1_req",   32'(mem_req), 32'd1);
        check("t1_dir",   32'(mem_dir), 32'd1);
        cycle();
        check("t1_consumed", 32'(instr_valida), 32'd0);
        check("t1_stale",    instr, 32'h0800_0000);

        // stall with two acks: O gets A, B gets B, requests stop
        stall = 1'b1; mem_listo = 1'b1;
        cycle();
        mem_ack = 1'b1; mem_dato = 32'hA000_0001;
        cycle();
        mem_ack = 1'b0;
        check("t2_oA",    instr, 32'hA000_0001);
        check("t2_pcA",   32'(pc_instr), 32'd1);
        check("t2_dir2",  32'(mem_dir), 32'd2);
        cycle();
        mem_ack = 1'b1; mem_dato = 32'hB000_0002;
        cycle();
        mem_ack = 1'b0;
        check("t2_req_bfull", 32'(mem_req), 32'd0);
        check("t2_hold_A",    instr, 32'hA000_0001);
        cycle();
        check("t2_req_still0", 32'(mem_req), 32'd0);
        check("t2_hold_A2",    instr, 32'hA000_0001);
        stall = 1'b0;
        cycle();
        check("t2_oB",    instr, 32'hB000_0002);
        check("t2_pcB",   32'(pc_instr), 32'd2);
        check("t2_validB", 32'(instr_valida), 32'd1);
        check("t2_req_re", 32'(mem_req), 32'd1);
        check("t2_dir3",   32'(mem_dir), 32'd3);

        // redirect while request to 3 is outstanding
        stall = 1'b1;
        cycle();
        check("t3_req_busy", 32'(mem_req), 32'd0);
        stall = 1'b0; salto_en = 1'b1; salto_dir = 16'h0040;
        cycle();
        salto_en = 1'b0;
        check("t3_flush", 32'(instr_valida), 32'd0);
        check("t3_req_wait", 32'(mem_req), 32'd0);
        mem_ack = 1'b1; mem_dato = 32'hDEAD_0003;
        cycle();
        mem_ack = 1'b0;
        check("t3_drop_valid", 32'(instr_valida), 32'd0);
        check("t3_drop_instr", instr, 32'hB000_0002);
        check("t3_req",   32'(mem_req), 32'd1);
        check("t3_dir40", 32'(mem_dir), 32'h0040);
        cycle();
        mem_ack = 1'b1; mem_dato = 32'h1000_0040;
        cycle();
        mem_ack = 1'b0;
        check("t3_valid", 32'(instr_valida), 32'd1);
        check("t3_instr", instr, 32'h1000_0040);
        check("t3_pc",    32'(pc_instr), 32'h0040);

        // redirect coinciding with an ack; target 0xFFFF also exercises wrap
        stall = 1'b1;
        cycle();
        stall = 1'b0; salto_en = 1'b1; salto_dir = 16'hFFFF;
        mem_ack = 1'b1; mem_dato = 32'hBAD0_0041;
        cycle();
        mem_ack = 1'b0; salto_en = 1'b0;
        check("t4_valid", 32'(instr_valida), 32'd0);
        check("t4_instr", instr, 32'h1000_0040);
        check("t4_req",   32'(mem_req), 32'd1);
        check("t4_dir",   32'(mem_dir), 32'hFFFF);
        cycle();
        mem_ack = 1'b1; mem_dato = 32'h2000_FFFF;
        cycle();
        mem_ack = 1'b0;
        check("t5_valid", 32'(instr_valida), 32'd1);
        check("t5_instr", instr, 32'h2000_FFFF);
        check("t5_pc",    32'(pc_instr), 32'hFFFF);
        check("t5_wrap",  32'(mem_dir), 32'h0000);

        // fill B under stall, then reset asynchronously
        stall = 1'b1;
        cycle();
        mem_ack = 1'b1; mem_dato = 32'h3000_0000;
        cycle();
        mem_ack = 1'b0;
        check("t6_bfull", 32'(mem_req), 32'd0);
        reset = 1'b1;
        #1;
        check("t6_async_valid", 32'(instr_valida), 32'd0);
        check("t6_async_instr", instr, 32'd0);
        check("t6_async_pc",    32'(pc_instr), 32'd0);
        check("t6_async_req",   32'(mem_req), 32'd0);
        check("t6_async_dir",   32'(mem_dir), 32'd0);
        cycle();
        reset = 1'b0; mem_listo = 1'b0; stall = 1'b0;
        mem_ack = 1'b1; mem_dato = 32'hFFFF_FFFF;
        cycle();
        mem_ack = 1'b0;
        check("t6_stray_valid", 32'(instr_valida), 32'd0);
        check("t6_stray_req",   32'(mem_req), 32'd1);
        check("t6_stray_dir",   32'(mem_dir), 32'd0);
        mem_listo = 1'b1;
        cycle();
        mem_ack = 1'b1; mem_dato = 32'h0800_0000;
        cycle();
        mem_ack = 1'b0;
        check("t6_restart_valid", 32'(instr_valida), 32'd1);
        check("t6_restart_instr", instr, 32'h0800_0000);
        check("t6_restart_pc",    32'(pc_instr), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

`default_nettype wire
